// File: rtl/pattern_pkg.sv
// Shared definitions for the memory-game pattern engine: FSM state codes, LFSR taps,
// key codes and the round-length clamp.
package pattern_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_GEN      = 3'd1;
    localparam state_t ST_SHOW_ON  = 3'd2;
    localparam state_t ST_SHOW_OFF = 3'd3;
    localparam state_t ST_INPUT    = 3'd4;
    localparam state_t ST_RESULT   = 3'd5;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] KEY_L = 2'd0;
    localparam logic [1:0] KEY_U = 2'd1;
    localparam logic [1:0] KEY_D = 2'd2;
    localparam logic [1:0] KEY_R = 2'd3;

    // A zero-length round is played as one symbol; oversize requests use full storage.
    function automatic int clamp_len(input int v, input int max_len);
        if (v < 1)
            return 1;
        if (v > max_len)
            return max_len;
        return v;
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 16-bit Galois LFSR (right shift, taps 16'hB400) supplying pattern symbols.
// Latency: q updates one cycle after adv; reset loads SEED (0 is forced to 1).
// Backpressure: none; advances only while adv is high.
module pattern_lfsr
    import pattern_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    localparam logic [15:0] INIT = (SEED == 16'd0) ? 16'd1 : SEED;

    always_ff @(posedge clk) begin
        if (rst)
            q <= INIT;
        else if (adv)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'd0);
    end

endmodule

// File: rtl/pattern_engine.sv
// Memory-game sequence engine: generate a random key pattern, play it back, check player keys.
// Latency: busy 1 cycle after start; GEN takes len cycles; key verdict and done 1 cycle after key_valid.
// Backpressure: none; step_en paces playback, keys outside INPUT are dropped. PATTERN_TIMEOUT_EN adds an idle-step timeout.
module pattern_engine
    import pattern_pkg::*;
#(
    parameter int          MAX_LEN       = 16,
    parameter int          KEY_W         = 2,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          TIMEOUT_STEPS = 8,
    localparam int         LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] seq_len,
    input  logic             step_en,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    output logic             busy,
    output logic             show_valid,
    output logic [KEY_W-1:0] show_code,
    output logic [LEN_W-1:0] show_idx,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] fail_idx
);

    localparam int IDX_W = $clog2(MAX_LEN);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] last_idx;
    logic [IDX_W-1:0] idx_lo;
    logic [KEY_W-1:0] mem [MAX_LEN];
    logic [KEY_W-1:0] cur_sym;
    logic [15:0]      lfsr_q;
    logic             is_last;
    logic             key_ok;
    logic             timeout_hit;
    logic             unused_lfsr_bits;

    pattern_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (state == ST_GEN),
        .q   (lfsr_q)
    );

    // Only the low bits become symbols; the rest of the register is LFSR state.
    assign unused_lfsr_bits = ^lfsr_q[15:KEY_W];

    // idx only reaches len after the final correct key, when mem is no longer read.
    assign idx_lo   = idx[IDX_W-1:0];
    assign cur_sym  = mem[idx_lo];
    assign last_idx = len - LEN_W'(1);
    assign is_last  = (idx == last_idx);
    assign key_ok   = (key_code == cur_sym);

`ifdef PATTERN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_STEPS + 1);

    logic [TO_W-1:0] tcnt;

    // A key in the same cycle as a step wins: the step does not count.
    assign timeout_hit = (state == ST_INPUT) && !key_valid && step_en &&
                         (tcnt == TO_W'(TIMEOUT_STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst || (state != ST_INPUT) || key_valid)
            tcnt <= '0;
        else if (step_en)
            tcnt <= tcnt + TO_W'(1);
    end
`else
    localparam int unused_timeout_steps = TIMEOUT_STEPS;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (state == ST_GEN)
            mem[idx_lo] <= lfsr_q[KEY_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            idx      <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_RESULT: begin
                    if (start) begin
                        len      <= LEN_W'(clamp_len(int'(seq_len), MAX_LEN));
                        idx      <= '0;
                        pass     <= 1'b0;
                        fail_idx <= '0;
                        state    <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (is_last) begin
                        idx   <= '0;
                        state <= ST_SHOW_OFF;
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                ST_SHOW_OFF: begin
                    if (step_en)
                        state <= ST_SHOW_ON;
                end
                ST_SHOW_ON: begin
                    if (step_en) begin
                        if (is_last) begin
                            idx   <= '0;
                            state <= ST_INPUT;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            state <= ST_SHOW_OFF;
                        end
                    end
                end
                ST_INPUT: begin
                    if (key_valid) begin
                        if (key_ok) begin
                            idx <= idx + LEN_W'(1);
                            if (is_last) begin
                                pass  <= 1'b1;
                                done  <= 1'b1;
                                state <= ST_RESULT;
                            end
                        end else begin
                            fail_idx <= idx;
                            done     <= 1'b1;
                            state    <= ST_RESULT;
                        end
                    end else if (timeout_hit) begin
                        fail_idx <= idx;
                        done     <= 1'b1;
                        state    <= ST_RESULT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_GEN) || (state == ST_SHOW_ON) ||
                        (state == ST_SHOW_OFF) || (state == ST_INPUT);
    assign show_valid = (state == ST_SHOW_ON);
    assign show_code  = show_valid ? cur_sym : '0;
    assign show_idx   = idx;

endmodule
